// File: rtl/sys_defs.sv
// Shared bus encodings, memory tag width and the data-port arbiter state enum.
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  localparam int MEM_TAG_BITS = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'h0,
    ISSUE     = 2'h1,
    WAIT_DATA = 2'h2
  } MEM_ARB_STATE;

endpackage

// File: rtl/mem_bus_arbiter_starve_ctr.sv
// Saturating icache starvation counter plus the data/icache grant decision.
module mem_arb_starve_ctr #(
  parameter int ICACHE_STARVE_MAX = 4,
  parameter int STARVE_BITS       = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   data_req,
  input  logic                   icache_req,
  input  logic                   resp_valid,
  output logic                   grant_data,
  output logic                   grant_icache,
  output logic [STARVE_BITS-1:0] starve_cnt
);

  localparam logic [STARVE_BITS-1:0] CNT_MAX = STARVE_BITS'(ICACHE_STARVE_MAX);

  logic icache_prio;

  // Once starved long enough the icache overrides data for one arbitration.
  assign icache_prio  = icache_req && (starve_cnt == CNT_MAX);
  assign grant_icache = icache_req && (!data_req || icache_prio);
  assign grant_data   = data_req && !grant_icache;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_icache && resp_valid) begin
      starve_cnt <= '0;
    end else if (grant_data && icache_req && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter between the icache and retire's data port.
// Optional MEM_ARB_DATA_BYPASS_EN: idle data commands drive the bus in their arrival cycle.
// Handshake: mem2proc_response != 0 in a cycle the bus carries a command means accepted;
// zero means the owner keeps driving identical outputs and retries next cycle.
`ifndef XLEN
`define XLEN 32
`endif

module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int ICACHE_STARVE_MAX = 4,
  parameter int STARVE_BITS       = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  BUS_COMMAND              d_command,
  input  logic [`XLEN-1:0]        d_addr,
  input  logic [63:0]             d_data,
  output logic                    d_busy,
  output logic                    d_load_valid,
  output logic [63:0]             d_load_data,
  input  BUS_COMMAND              icache_command,
  input  logic [`XLEN-1:0]        icache_addr,
  output logic [3:0]              icache_response,
  output BUS_COMMAND              proc2mem_command,
  output logic [`XLEN-1:0]        proc2mem_addr,
  output logic [63:0]             proc2mem_data,
  input  logic [3:0]              mem2proc_response,
  input  logic [63:0]             mem2proc_data,
  input  logic [MEM_TAG_BITS-1:0] mem2proc_tag,
  output MEM_ARB_STATE            dbg_state,
  output logic [STARVE_BITS-1:0]  dbg_starve_cnt
);

  MEM_ARB_STATE            state_q, state_d;
  BUS_COMMAND              held_cmd_q, held_cmd_d;
  logic [`XLEN-1:0]        held_addr_q, held_addr_d;
  logic [63:0]             held_data_q, held_data_d;
  logic [MEM_TAG_BITS-1:0] held_tag_q, held_tag_d;

  logic data_req, icache_req, resp_valid, grant_data, grant_icache, accept;

`ifdef MEM_ARB_DATA_BYPASS_EN
  assign data_req = !reset && ((state_q == ISSUE) ||
                               ((state_q == IDLE) && (d_command != BUS_NONE)));
`else
  assign data_req = !reset && (state_q == ISSUE);
`endif
  assign icache_req = !reset && (icache_command == BUS_LOAD);
  assign resp_valid = (mem2proc_response != 4'h0);
  assign accept     = grant_data && resp_valid;

  mem_arb_starve_ctr #(
    .ICACHE_STARVE_MAX(ICACHE_STARVE_MAX),
    .STARVE_BITS      (STARVE_BITS)
  ) u_starve_ctr (
    .clock       (clock),
    .reset       (reset),
    .data_req    (data_req),
    .icache_req  (icache_req),
    .resp_valid  (resp_valid),
    .grant_data  (grant_data),
    .grant_icache(grant_icache),
    .starve_cnt  (dbg_starve_cnt)
  );

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_data) begin
      // A bypassed command comes straight from the ports; otherwise from the latch.
      if (state_q == ISSUE) begin
        proc2mem_command = held_cmd_q;
        proc2mem_addr    = held_addr_q;
        proc2mem_data    = held_data_q;
      end else begin
        proc2mem_command = d_command;
        proc2mem_addr    = d_addr;
        proc2mem_data    = d_data;
      end
    end else if (grant_icache) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = icache_addr;
    end
  end

  always_comb begin
    state_d      = state_q;
    held_cmd_d   = held_cmd_q;
    held_addr_d  = held_addr_q;
    held_data_d  = held_data_q;
    held_tag_d   = held_tag_q;
    d_load_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_command != BUS_NONE) begin
          if (accept) begin
            if (d_command == BUS_LOAD) begin
              held_tag_d = mem2proc_response;
              state_d    = WAIT_DATA;
            end
          end else begin
            held_cmd_d  = d_command;
            held_addr_d = d_addr;
            held_data_d = d_data;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (accept) begin
          if (held_cmd_q == BUS_LOAD) begin
            held_tag_d = mem2proc_response;
            state_d    = WAIT_DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_DATA: begin
        if (!reset && (held_tag_q != '0) && (mem2proc_tag == held_tag_q)) begin
          d_load_valid = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      held_cmd_q  <= BUS_NONE;
      held_addr_q <= '0;
      held_data_q <= '0;
      held_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      held_cmd_q  <= held_cmd_d;
      held_addr_q <= held_addr_d;
      held_data_q <= held_data_d;
      held_tag_q  <= held_tag_d;
    end
  end

  assign d_busy          = !reset && (state_q != IDLE);
  assign d_load_data     = d_load_valid ? mem2proc_data : 64'h0;
  assign icache_response = grant_icache ? mem2proc_response : 4'h0;
  assign dbg_state       = state_q;

  // Retire must never present a memory op while one is in flight; such a command is ignored.
  no_cmd_while_busy: assert property (@(posedge clock) disable iff (reset)
    !(d_busy && (d_command != BUS_NONE)));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-vector bench for mem_bus_arbiter with hand-computed expectations.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_bus_arbiter;
  import sys_defs::*;

  logic             clock;
  logic             reset;
  BUS_COMMAND       d_command;
  logic [`XLEN-1:0] d_addr;
  logic [63:0]      d_data;
  logic             d_busy;
  logic             d_load_valid;
  logic [63:0]      d_load_data;
  BUS_COMMAND       icache_command;
  logic [`XLEN-1:0] icache_addr;
  logic [3:0]       icache_response;
  BUS_COMMAND       proc2mem_command;
  logic [`XLEN-1:0] proc2mem_addr;
  logic [63:0]      proc2mem_data;
  logic [3:0]       mem2proc_response;
  logic [63:0]      mem2proc_data;
  logic [3:0]       mem2proc_tag;
  MEM_ARB_STATE     dbg_state;
  logic [2:0]       dbg_starve_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  mem_bus_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .d_command        (d_command),
    .d_addr           (d_addr),
    .d_data           (d_data),
    .d_busy           (d_busy),
    .d_load_valid     (d_load_valid),
    .d_load_data      (d_load_data),
    .icache_command   (icache_command),
    .icache_addr      (icache_addr),
    .icache_response  (icache_response),
    .proc2mem_command (proc2mem_command),
    .proc2mem_addr    (proc2mem_addr),
    .proc2mem_data    (proc2mem_data),
    .mem2proc_response(mem2proc_response),
    .mem2proc_data    (mem2proc_data),
    .mem2proc_tag     (mem2proc_tag),
    .dbg_state        (dbg_state),
    .dbg_starve_cnt   (dbg_starve_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_idle();
    d_command         = BUS_NONE;
    d_addr            = '0;
    d_data            = '0;
    icache_command    = BUS_NONE;
    icache_addr       = '0;
    mem2proc_response = '0;
    mem2proc_data     = '0;
    mem2proc_tag      = '0;
  endtask

  task automatic next();
    @(negedge clock);
    set_idle();
  endtask

  // scoreboard: expected load data is queued at issue and consumed on the pulse
  task automatic check_load_pulse(input string tag);
    logic [63:0] e;
    check({tag, "_valid"}, d_load_valid, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_q_nonempty"}, 1'b0, 1'b1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, d_load_data, e);
    end
  endtask

  task automatic check_bus(input string tag, input BUS_COMMAND c,
                           input logic [`XLEN-1:0] a, input logic [63:0] d);
    check({tag, "_cmd"}, proc2mem_command, c);
    check({tag, "_addr"}, proc2mem_addr, a);
    check({tag, "_data"}, proc2mem_data, d);
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_starve", dbg_starve_cnt, 3'd0);
    check("rst_busy", d_busy, 1'b0);
    check_bus("rst_bus", BUS_NONE, '0, '0);
    reset = 1'b0;

    // store, no icache traffic
    next(); d_command = BUS_STORE; d_addr = 32'h100; d_data = 64'hDEAD_BEEF; #1;
    check("st_c0_busy", d_busy, 1'b0);
`ifdef MEM_ARB_DATA_BYPASS_EN
    check("st_c0_cmd", proc2mem_command, BUS_STORE);
`else
    check("st_c0_cmd", proc2mem_command, BUS_NONE);
`endif
    next(); mem2proc_response = 4'd3; #1;
    check("st_c1_busy", d_busy, 1'b1);
    check_bus("st_c1", BUS_STORE, 32'h100, 64'hDEAD_BEEF);
    next(); #1;
    check("st_c2_state", dbg_state, IDLE);
    check("st_c2_busy", d_busy, 1'b0);

    // load accepted with tag 5, stray tags 2 and 7 first
    next(); d_command = BUS_LOAD; d_addr = 32'h200; #1;
    exp_q.push_back(64'h1234);
    next(); mem2proc_response = 4'd5; #1;
    check_bus("ld_c1", BUS_LOAD, 32'h200, 64'h0);
    next(); mem2proc_tag = 4'd2; mem2proc_data = 64'hBAD2; #1;
    check("ld_c2_state", dbg_state, WAIT_DATA);
    check("ld_c2_valid", d_load_valid, 1'b0);
    check("ld_c2_ldata", d_load_data, 64'h0);
    next(); mem2proc_tag = 4'd7; mem2proc_data = 64'hBAD7; #1;
    check("ld_c3_valid", d_load_valid, 1'b0);
    check("ld_c3_busy", d_busy, 1'b1);
    next(); #1;
    check("ld_c4_valid", d_load_valid, 1'b0);
    next(); mem2proc_tag = 4'd5; mem2proc_data = 64'h1234; #1;
    check_load_pulse("ld_c5");
    check("ld_c5_busy", d_busy, 1'b1);
    next(); mem2proc_tag = 4'd5; mem2proc_data = 64'h1234; #1;
    check("ld_c6_valid", d_load_valid, 1'b0);
    check("ld_c6_busy", d_busy, 1'b0);
    check("ld_c6_state", dbg_state, IDLE);

    // memory rejects three times, then accepts
    next(); d_command = BUS_STORE; d_addr = 32'h300; d_data = 64'hABCD; #1;
    for (int i = 0; i < 3; i++) begin
      next(); #1;
      check_bus($sformatf("rej_c%0d", i + 1), BUS_STORE, 32'h300, 64'hABCD);
      check($sformatf("rej_c%0d_state", i + 1), dbg_state, ISSUE);
    end
    next(); mem2proc_response = 4'd4; #1;
    check_bus("rej_acc", BUS_STORE, 32'h300, 64'hABCD);
    next(); #1;
    check("rej_done_state", dbg_state, IDLE);

`ifndef MEM_ARB_DATA_BYPASS_EN
    // starvation: icache keeps requesting while data is rejected
    next(); d_command = BUS_LOAD; d_addr = 32'h500;
    icache_command = BUS_LOAD; icache_addr = 32'h400; #1;
    check_bus("stv_c0", BUS_LOAD, 32'h400, 64'h0);
    check("stv_c0_iresp", icache_response, 4'd0);
    exp_q.push_back(64'h77);
    for (int i = 1; i <= 4; i++) begin
      next(); icache_command = BUS_LOAD; icache_addr = 32'h400; #1;
      check($sformatf("stv_c%0d_cnt", i), dbg_starve_cnt, 3'(i - 1));
      check($sformatf("stv_c%0d_addr", i), proc2mem_addr, 32'h500);
    end
    next(); icache_command = BUS_LOAD; icache_addr = 32'h400; mem2proc_response = 4'd6; #1;
    check("stv_c5_cnt", dbg_starve_cnt, 3'd4);
    check("stv_c5_addr", proc2mem_addr, 32'h400);
    check("stv_c5_iresp", icache_response, 4'd6);
    next(); icache_command = BUS_LOAD; icache_addr = 32'h400; mem2proc_response = 4'd7; #1;
    check("stv_c6_cnt", dbg_starve_cnt, 3'd0);
    check_bus("stv_c6", BUS_LOAD, 32'h500, 64'h0);
    check("stv_c6_iresp", icache_response, 4'd0);
    next(); mem2proc_tag = 4'd7; mem2proc_data = 64'h77; #1;
    check_load_pulse("stv_c7");
    next(); #1;
    check("stv_c8_state", dbg_state, IDLE);
`endif

    // reset while a load with tag 6 is outstanding
    next(); d_command = BUS_LOAD; d_addr = 32'h600; #1;
    next(); mem2proc_response = 4'd6; #1;
    next(); #1;
    check("rw_pre_state", dbg_state, WAIT_DATA);
    reset = 1'b1; #1;
    check("rw_in_busy", d_busy, 1'b0);
    next(); reset = 1'b0; mem2proc_tag = 4'd6; mem2proc_data = 64'h66; #1;
    check("rw_valid", d_load_valid, 1'b0);
    check("rw_ldata", d_load_data, 64'h0);
    check("rw_state", dbg_state, IDLE);
    check("rw_busy", d_busy, 1'b0);
    check("rw_starve", dbg_starve_cnt, 3'd0);
    check("rw_iresp", icache_response, 4'd0);
    check_bus("rw_bus", BUS_NONE, '0, '0);

`ifdef MEM_ARB_DATA_BYPASS_EN
    // bypass: idle load accepted in its arrival cycle
    next(); d_command = BUS_LOAD; d_addr = 32'h700; mem2proc_response = 4'd9; #1;
    check_bus("byp_c0", BUS_LOAD, 32'h700, 64'h0);
    check("byp_c0_busy", d_busy, 1'b0);
    exp_q.push_back(64'h99);
    next(); #1;
    check("byp_c1_state", dbg_state, WAIT_DATA);
    next(); mem2proc_tag = 4'd9; mem2proc_data = 64'h99; #1;
    check_load_pulse("byp_c2");
`endif

    next(); #1;
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
